inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Instruction fetch front end of the out-of-order core. Holds the PC, issues one-word fetch requests to the memory interface, and buffers returned 32-bit instructions with their PCs in a small FIFO instruction queue. The decoder and dispatcher consume the queue head. A redirect from the reorder buffer flushes all in-flight fetch state.

## Interface
Parameters:
- IQ_WIDTH, 2, log2 of instruction-queue depth; depth DEPTH = 1 << IQ_WIDTH
- RESET_PC, 32'h0, PC loaded on reset

Ports:
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-high reset
- mem_req  output  1  fetch request valid
- mem_addr  output  32  fetch address; always word-aligned, bits [1:0] = 0
- mem_done  input  1  one-cycle pulse: mem_data is valid for the outstanding request
- mem_data  input  32  fetched instruction word
- inst_valid  output  1  queue non-empty; head entry presented
- inst_out  output  32  head instruction
- inst_pc  output  32  PC of head instruction
- inst_pred_taken  output  1  head was fetched with a predicted-taken next PC (0 when the macro is off)
- issue_ready  input  1  consumer accepts head this cycle
- flush_in  input  1  redirect from the reorder buffer
- flush_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0

## Operation
- State machine FSM ∈ {IDLE, WAIT_MEM, DISCARD}. Reset value is IDLE.
- Reset:
  - pc = RESET_PC.
  - Queue empty: head = tail = count = 0.
  - Outputs: mem_req = 0, mem_addr = 0, inst_valid = 0, inst_out = 0, inst_pc = 0, inst_pred_taken = 0.
- IDLE:
  - If count < DEPTH and no flush this cycle, register mem_req = 1 and mem_addr = pc, then go to WAIT_MEM.
  - Otherwise stay in IDLE with mem_req = 0.
- WAIT_MEM:
  - mem_req and mem_addr are held stable until mem_done.
  - On mem_done, push {mem_data, pc, pred} at tail and set pc = next_pc.
  - After the push, drop mem_req and return to IDLE.
  - Only one request is ever outstanding.
  - Space for the returning word is reserved when the request is issued, so a push never finds the queue full.
- DISCARD:
  - mem_req is held until mem_done.
  - The returned word is dropped, then the FSM goes to IDLE.
- next_pc = pc + 4, with 32-bit wrap-around: 32'hFFFFFFFC + 4 = 0.
- Pop: when inst_valid && issue_ready, head advances. Head and tail pointers wrap modulo DEPTH.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Flush has priority over all other events in the same cycle:
  - Queue is cleared and any pop that cycle is ignored.
  - pc = {flush_pc[31:2], 2'b00}.
  - WAIT_MEM without mem_done that cycle: go to DISCARD.
  - WAIT_MEM with mem_done that cycle: the word is dropped and the FSM goes to IDLE.
  - DISCARD: stays in DISCARD, or goes to IDLE if mem_done arrives the same cycle.
  - IDLE: stays IDLE. The new fetch starts the following cycle.
- mem_done while in IDLE (protocol violation) is ignored.
- Reset mid-operation: returns immediately to reset values. A later stray mem_done is ignored.

## Timing
- Request: mem_req rises 1 cycle after entering IDLE with space available.
- Best-case mem_done is the cycle after mem_req rises.
- Fetch-to-issue: a word pushed on edge N is visible on inst_valid/inst_out after edge N. It can be popped in cycle N+1.
- Back-to-back fetch throughput: one instruction every (memory latency + 1) cycles. The extra cycle is the IDLE turnaround.
- Flush on edge F:
  - inst_valid = 0 after F.
  - The earliest new request is registered on edge F+1, with mem_addr = flush target.
  - If the FSM entered DISCARD, the new request waits until mem_done, then IDLE, then the request.
- Queue-full stall: the request is issued the cycle after a pop frees a slot.

## Configuration
- FETCH_JAL_PREDICT_EN defined:
  - A returned word with mem_data[6:0] = 7'b1101111 (JAL) sets next_pc = pc + sext({mem_data[31], mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0}).
  - That entry is stored with pred = 1.
  - All other words: next_pc = pc + 4, pred = 0.
- Macro not defined: next_pc is always pc + 4 and inst_pred_taken is tied to 0.

## Test plan
- Reset with RESET_PC = 0, memory returning addr+100 after 2 cycles, issue_ready = 1 → mem_addr sequence 0, 4, 8; inst_out 100, 104, 108 paired with inst_pc 0, 4, 8.
- issue_ready = 0, DEPTH = 4 → exactly 4 fetches (0..12), mem_req then stays 0. Raise issue_ready for 1 cycle → the next request has mem_addr = 16.
- flush_in with flush_pc = 32'h1003 while in WAIT_MEM, mem_done arriving 3 cycles later → that word is not queued; next mem_addr = 32'h1000; inst_valid = 0 from the flush edge until the new word arrives.
- flush_in in the same cycle as mem_done and a pop → queue empty, word dropped, FSM IDLE, next mem_addr = flush target.
- Wrap-around: RESET_PC = 32'hFFFFFFFC → fetches FFFFFFFC then 0. Pointer wrap after 9 push/pop pairs with DEPTH = 4 preserves FIFO order.
- With FETCH_JAL_PREDICT_EN, word 32'h0100006F (jal x0, +16) at pc 0x20 → next mem_addr = 0x30; head has inst_pred_taken = 1.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// Fetch-side bundle between inst_fetcher and its memory, decoder/dispatcher and reorder buffer.
// Handshakes: mem_req/mem_addr stay stable until a one-cycle mem_done; a queue entry transfers on every cycle with inst_valid && issue_ready.
interface inst_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_pred_taken;
    logic        issue_ready;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic [1:0]  fsm_state;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_pred_taken, fsm_state,
        input  mem_done, mem_data, issue_ready, flush_in, flush_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_pred_taken, fsm_state,
        output mem_done, mem_data, issue_ready, flush_in, flush_pc
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: PC, single outstanding memory fetch, FIFO instruction queue.
// Optional JAL next-PC prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module inst_fetcher #(
    parameter int          IQ_WIDTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic            clk_in,
    input logic            rst_in,
    inst_fetcher_if.master bus
);
    localparam int DEPTH = 1 << IQ_WIDTH;
    localparam logic [IQ_WIDTH:0] FULL = (IQ_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [31:0]         pc, pc_n, addr_n, next_pc, flush_target;
    logic                req_n, push, pop, clear;
    logic [31:0]         data_q [DEPTH];
    logic [31:0]         pc_q   [DEPTH];
    logic [IQ_WIDTH-1:0] head, tail;
    logic [IQ_WIDTH:0]   count;

    assign flush_target = bus.flush_pc & 32'hFFFF_FFFC;

`ifdef FETCH_JAL_PREDICT_EN
    logic             pred;
    logic [31:0]      jal_imm;
    logic [DEPTH-1:0] pred_q;

    assign pred    = (bus.mem_data[6:0] == 7'b1101111);
    assign jal_imm = {{11{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                      bus.mem_data[20], bus.mem_data[30:21], 1'b0};
    assign next_pc = pc + (pred ? jal_imm : 32'd4);
    assign bus.inst_pred_taken = bus.inst_valid & pred_q[head];
`else
    assign next_pc = pc + 32'd4;
    assign bus.inst_pred_taken = 1'b0;
`endif

    // Outputs read zero while the queue is empty so the array itself needs no reset.
    assign bus.inst_valid = (count != '0);
    assign bus.inst_out   = bus.inst_valid ? data_q[head] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? pc_q[head] : 32'h0;
    assign bus.fsm_state  = state;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = bus.mem_req;
        addr_n  = bus.mem_addr;
        push    = 1'b0;
        clear   = 1'b0;
        pop     = bus.inst_valid && bus.issue_ready;
        if (bus.flush_in) begin
            clear = 1'b1;
            pop   = 1'b0;
            pc_n  = flush_target;
        end
        case (state)
            IDLE: begin
                // Only one fetch is ever in flight, so a free slot now is a slot at return.
                if (!bus.flush_in && count < FULL) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_done) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                    if (!bus.flush_in) begin
                        push = 1'b1;
                        pc_n = next_pc;
                    end
                end else if (bus.flush_in) begin
                    state_n = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem_done) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= 32'h0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            bus.mem_req  <= req_n;
            bus.mem_addr <= addr_n;
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            data_q[tail] <= bus.mem_data;
            pc_q[tail]   <= pc;
`ifdef FETCH_JAL_PREDICT_EN
            pred_q[tail] <= pred;
`endif
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: directed scenarios push expected request addresses and
// queue entries; a negedge monitor compares every new request and every accepted head entry.
module tb_inst_fetcher;
    logic clk = 1'b0;
    logic rst_in;
    inst_fetcher_if bus();

    inst_fetcher #(.IQ_WIDTH(2), .RESET_PC(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];       // expected mem_addr of each new request
    logic [64:0] exp_inst_q[$];  // expected {pred, pc, inst} of each accepted head

    int          lat = 1;
    int          resp_budget = 0;
    int          resp_used = 0;
    int          man_cnt = 0;
    int          man_seen = 0;
    logic [31:0] man_data = 32'h0;
    bit          jal_mode = 1'b0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    endtask

    task automatic fail_now(input string name, input logic [64:0] act);
        n_checks++;
        $display("FAIL %s: actual=%h required=none (t=%0t)", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] resp(input logic [31:0] a);
        if (jal_mode && a == 32'h20) return 32'h0100006F;
        return a + 32'd100;
    endfunction

    // Memory model: answers up to resp_budget requests after lat cycles, plus manual pulses.
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] req_addr = 32'h0;
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_in) busy = 1'b0;
            if (bus.mem_done) begin
                bus.mem_done = 1'b0;
            end else if (man_cnt != man_seen) begin
                man_seen     = man_cnt;
                bus.mem_done = 1'b1;
                bus.mem_data = man_data;
            end else if (busy) begin
                if (wcnt == 0) begin
                    bus.mem_done = 1'b1;
                    bus.mem_data = resp(req_addr);
                    busy         = 1'b0;
                end else begin
                    wcnt--;
                end
            end else if (!rst_in && bus.mem_req && resp_used < resp_budget) begin
                busy     = 1'b1;
                wcnt     = lat - 1;
                req_addr = bus.mem_addr;
                resp_used++;
            end
        end
    end

    // Monitor
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always @(negedge clk) begin
        if (rst_in) begin
            prev_req = 1'b0;
        end else begin
            if (bus.mem_req && !prev_req) begin
                if (exp_q.size() == 0) fail_now("req_unexpected", 65'(bus.mem_addr));
                else chk("req_addr", 65'(bus.mem_addr), 65'(exp_q.pop_front()));
            end
            if (bus.mem_req && prev_req)
                chk("addr_stable", 65'(bus.mem_addr), 65'(prev_addr));
            if (bus.inst_valid && bus.issue_ready && !bus.flush_in) begin
                if (exp_inst_q.size() == 0)
                    fail_now("pop_unexpected", {bus.inst_pred_taken, bus.inst_pc, bus.inst_out});
                else
                    chk("pop_head", {bus.inst_pred_taken, bus.inst_pc, bus.inst_out}, exp_inst_q.pop_front());
            end
            prev_req  = bus.mem_req;
            prev_addr = bus.mem_addr;
        end
    end

    task automatic do_reset();
        rst_in          = 1'b1;
        bus.flush_in    = 1'b0;
        bus.issue_ready = 1'b0;
        jal_mode        = 1'b0;
        resp_budget     = resp_used;
        tick();
        man_data = 32'hBAD0_0000;  // stray completion while held in reset
        man_cnt++;
        tick();
        tick();
        tick();
        exp_q.delete();
        exp_inst_q.delete();
        chk("rst_mem_req",    65'(bus.mem_req), 65'(0));
        chk("rst_mem_addr",   65'(bus.mem_addr), 65'(0));
        chk("rst_inst_valid", 65'(bus.inst_valid), 65'(0));
        chk("rst_inst_out",   65'(bus.inst_out), 65'(0));
        chk("rst_inst_pc",    65'(bus.inst_pc), 65'(0));
        chk("rst_pred",       65'(bus.inst_pred_taken), 65'(0));
        chk("rst_fsm",        65'(bus.fsm_state), 65'(0));
    endtask

    task automatic wait_addr_left(input int n, input int budget);
        int c = 0;
        while (exp_q.size() > n && c < budget) begin
            tick();
            c++;
        end
        chk("wait_req_timeout", 65'(exp_q.size() <= n), 65'(1));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || exp_inst_q.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        chk("drain_timeout", 65'(exp_q.size() == 0 && exp_inst_q.size() == 0), 65'(1));
    endtask

    task automatic add_inst(input logic pred, input logic [31:0] pc, input logic [31:0] inst);
        exp_inst_q.push_back({pred, pc, inst});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in          = 1'b1;
        bus.issue_ready = 1'b0;
        bus.flush_in    = 1'b0;
        bus.flush_pc    = 32'h0;

        // Straight-line fetch, 2-cycle memory, consumer always ready.
        do_reset();
        lat = 2;
        resp_budget = resp_used + 3;
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 3; i++) add_inst(1'b0, 32'(i * 4), 32'(100 + i * 4));
        rst_in = 1'b0;
        drain(100);

        // Queue fills with consumer stalled, then one pop releases the next fetch.
        do_reset();
        lat = 1;
        resp_budget = resp_used + 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        rst_in = 1'b0;
        wait_addr_left(0, 100);
        repeat (10) tick();
        chk("full_no_req",    65'(bus.mem_req), 65'(0));
        chk("full_fsm_idle",  65'(bus.fsm_state), 65'(0));
        chk("full_valid",     65'(bus.inst_valid), 65'(1));
        exp_q.push_back(32'd16);
        add_inst(1'b0, 32'h0, 32'd100);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        tick();
        chk("stall_release_req", 65'(bus.mem_req), 65'(1));
        drain(20);

        // Flush while waiting on memory; the late word is discarded.
        do_reset();
        lat = 1;
        resp_budget = resp_used + 1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1004);
        rst_in = 1'b0;
        wait_addr_left(2, 50);
        chk("pre_flush_valid", 65'(bus.inst_valid), 65'(1));
        bus.flush_in = 1'b1;
        bus.flush_pc = 32'h1003;
        tick();
        bus.flush_in = 1'b0;
        chk("flush_valid",    65'(bus.inst_valid), 65'(0));
        chk("flush_discard",  65'(bus.fsm_state), 65'(2));
        chk("discard_req",    65'(bus.mem_req), 65'(1));
        bus.issue_ready = 1'b1;
        tick();
        tick();
        chk("discard_valid",  65'(bus.inst_valid), 65'(0));
        man_data = 32'hDEAD_BEEF;
        man_cnt++;
        tick();
        chk("discard_done_req",  65'(bus.mem_req), 65'(0));
        chk("discard_done_fsm",  65'(bus.fsm_state), 65'(0));
        chk("discard_done_valid", 65'(bus.inst_valid), 65'(0));
        tick();
        chk("refetch_fsm", 65'(bus.fsm_state), 65'(1));
        add_inst(1'b0, 32'h1000, 32'h1234_5678);
        man_data = 32'h1234_5678;
        man_cnt++;
        drain(30);

        // Flush, mem_done and a pop all in the same cycle.
        do_reset();
        lat = 1;
        resp_budget = resp_used + 1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h2004);
        rst_in = 1'b0;
        wait_addr_left(2, 50);
        chk("pre_flush2_valid", 65'(bus.inst_valid), 65'(1));
        bus.flush_in    = 1'b1;
        bus.flush_pc    = 32'h2000;
        bus.issue_ready = 1'b1;
        man_data = 32'h7777_7777;
        man_cnt++;
        tick();
        bus.flush_in = 1'b0;
        chk("flush2_valid", 65'(bus.inst_valid), 65'(0));
        chk("flush2_fsm",   65'(bus.fsm_state), 65'(0));
        chk("flush2_req",   65'(bus.mem_req), 65'(0));
        tick();
        chk("flush2_newreq", 65'(bus.mem_req), 65'(1));
        chk("flush2_wait",   65'(bus.fsm_state), 65'(1));
        add_inst(1'b0, 32'h2000, 32'hCAFE_F00D);
        man_data = 32'hCAFE_F00D;
        man_cnt++;
        drain(30);

        // PC wrap-around from the top of the address space.
        do_reset();
        lat = 1;
        resp_budget = resp_used + 2;
        bus.issue_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        add_inst(1'b0, 32'hFFFF_FFFC, 32'h60);
        add_inst(1'b0, 32'h0, 32'd100);
        rst_in = 1'b0;
        bus.flush_in = 1'b1;
        bus.flush_pc = 32'hFFFF_FFFC;
        tick();
        bus.flush_in = 1'b0;
        chk("idle_flush_req", 65'(bus.mem_req), 65'(0));
        chk("idle_flush_fsm", 65'(bus.fsm_state), 65'(0));
        drain(60);

        // Nine push/pop pairs with a sparse consumer: pointer wrap keeps FIFO order.
        do_reset();
        lat = 1;
        resp_budget = resp_used + 9;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 9; i++) add_inst(1'b0, 32'(i * 4), 32'(100 + i * 4));
        rst_in = 1'b0;
        for (int c = 0; c < 300 && (exp_q.size() != 0 || exp_inst_q.size() != 0); c++) begin
            bus.issue_ready = (c % 4 == 0);
            tick();
        end
        chk("wrap_drain", 65'(exp_q.size() == 0 && exp_inst_q.size() == 0), 65'(1));

        // JAL word at 0x20.
        do_reset();
        jal_mode = 1'b1;
        lat = 1;
        resp_budget = resp_used + 2;
        bus.issue_ready = 1'b1;
        exp_q.push_back(32'h20);
`ifdef FETCH_JAL_PREDICT_EN
        exp_q.push_back(32'h30);
        exp_q.push_back(32'h34);
        add_inst(1'b1, 32'h20, 32'h0100_006F);
        add_inst(1'b0, 32'h30, 32'h94);
`else
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h28);
        add_inst(1'b0, 32'h20, 32'h0100_006F);
        add_inst(1'b0, 32'h24, 32'h88);
`endif
        rst_in = 1'b0;
        bus.flush_in = 1'b1;
        bus.flush_pc = 32'h20;
        tick();
        bus.flush_in = 1'b0;
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
